// File: rtl/exec_pkg.sv
// Shared opcodes, FSM state encoding and flag layout for the exec/writeback stage.
package exec_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd9;
    localparam logic [3:0] OP_ADDI = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_INC  = 4'd13;
    localparam logic [3:0] OP_DEC  = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
    localparam int F_V = 3;

    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic c, input logic z);
        logic [3:0] f;
        f      = 4'b0000;
        f[F_V] = v;
        f[F_N] = n;
        f[F_C] = c;
        f[F_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/exec_wb_alu8.sv
// Combinational single-cycle ALU: result plus carry/borrow and signed overflow.
module alu8
    import exec_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] imm_i,
    output logic [DW-1:0] res_o,
    output logic          c_o,
    output logic          v_o
);

    localparam logic [DW-1:0] ONE = DW'(1);

    logic [DW-1:0] opnd_s;
    logic [DW:0]   sum_s;
    logic [DW:0]   diff_s;

    // Second operand shared by the adder and subtractor; diff_s[DW] is the unsigned borrow.
    always_comb begin
        case (op_i)
            OP_ADDI: opnd_s = imm_i;
            OP_INC:  opnd_s = ONE;
            OP_DEC:  opnd_s = ONE;
            default: opnd_s = b_i;
        endcase
        sum_s  = {1'b0, a_i} + {1'b0, opnd_s};
        diff_s = {1'b0, a_i} - {1'b0, opnd_s};
    end

    // Result and C/V selection per opcode.
    always_comb begin
        res_o = '0;
        c_o   = 1'b0;
        v_o   = 1'b0;
        case (op_i)
            OP_ADD, OP_ADDI, OP_INC: begin
                res_o = sum_s[DW-1:0];
                c_o   = sum_s[DW];
                v_o   = (a_i[DW-1] == opnd_s[DW-1]) && (sum_s[DW-1] != a_i[DW-1]);
            end
            OP_SUB, OP_CMP, OP_DEC: begin
                res_o = diff_s[DW-1:0];
                c_o   = diff_s[DW];
                v_o   = (a_i[DW-1] != opnd_s[DW-1]) && (diff_s[DW-1] != a_i[DW-1]);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_SHL: begin
                res_o = {a_i[DW-2:0], 1'b0};
                c_o   = a_i[DW-1];
            end
            OP_SHR: begin
                res_o = {1'b0, a_i[DW-1:1]};
                c_o   = a_i[0];
            end
            OP_MOV: res_o = b_i;
            OP_LDI: res_o = imm_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_wb.sv
// Execute/writeback stage: latches one decoded op, runs the ALU or the 8-step
// shift-add multiplier, updates flags and issues a single-cycle regfile write.
module exec_wb
    import exec_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [DW-1:0] in_imm,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [3:0]    flags,
    output logic          busy,
    output logic          illegal
);

    state_t        state_q;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] ma_q;
    logic [DW-1:0] mb_q;
    logic [2:0]    cnt_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    flags_q;
    logic          illegal_q;

    logic [DW-1:0] alu_res_s;
    logic          alu_c_s;
    logic          alu_v_s;
    logic [DW-1:0] acc_d;

    alu8 #(.DW(DW)) u_alu (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .imm_i (imm_q),
        .res_o (alu_res_s),
        .c_o   (alu_c_s),
        .v_o   (alu_v_s)
    );

    // Accumulator value after the current multiply iteration.
    always_comb begin
        acc_d = acc_q + (mb_q[0] ? ma_q : '0);
    end

    // Stage FSM with operand latches, multiply datapath, flags and writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            acc_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            cnt_q     <= 3'd0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        rd_q    <= in_rd;
                        a_q     <= in_a;
                        b_q     <= in_b;
                        imm_q   <= in_imm;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_NOP: state_q <= IDLE;
                        OP_RSVD: begin
                            illegal_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                        OP_CMP: begin
                            flags_q <= pack_flags(alu_v_s, alu_res_s[DW-1], alu_c_s,
                                                  alu_res_s == '0);
                            state_q <= IDLE;
                        end
                        OP_MUL: begin
                            acc_q   <= '0;
                            ma_q    <= a_q;
                            mb_q    <= b_q;
                            cnt_q   <= 3'd0;
                            state_q <= MUL;
                        end
                        default: begin
                            flags_q <= pack_flags(alu_v_s, alu_res_s[DW-1], alu_c_s,
                                                  alu_res_s == '0);
                            wdata_q <= alu_res_s;
                            waddr_q <= rd_q;
                            we_q    <= 1'b1;
                            state_q <= WB;
                        end
                    endcase
                end
                MUL: begin
                    acc_q <= acc_d;
                    ma_q  <= {ma_q[DW-2:0], 1'b0};
                    mb_q  <= {1'b0, mb_q[DW-1:1]};
                    cnt_q <= cnt_q + 3'd1;
                    // The eighth iteration retires straight into writeback.
                    if (cnt_q == 3'd7) begin
                        flags_q <= pack_flags(1'b0, acc_d[DW-1], 1'b0, acc_d == '0);
                        wdata_q <= acc_d;
                        waddr_q <= rd_q;
                        we_q    <= 1'b1;
                        state_q <= WB;
                    end
                end
                WB: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign flags    = flags_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_exec_wb.sv
// Self-checking bench for exec_wb: vector table, writeback scoreboard, reset corner cases.
module tb_exec_wb;
    import exec_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [2:0] in_rd;
    logic [7:0] in_a, in_b, in_imm;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [3:0] flags;
    logic       busy;
    logic       illegal;

    always #5 clk = ~clk;

    exec_wb dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .we(we), .waddr(waddr), .wdata(wdata), .flags(flags), .busy(busy),
        .illegal(illegal)
    );

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] a, b, imm;
        logic       wr;
        logic [7:0] wd;
        logic [3:0] fl;
        int         we_n;
        int         rdy_n;
        int         ill;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [10:0] sbq[$];
    logic [10:0] sb_e;
    logic [7:0]  rf[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] rd,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm,
                                input logic wr, input logic [7:0] wd, input logic [3:0] fl,
                                input int we_n, input int rdy_n, input int ill);
        vec_t v;
        v.op = op; v.rd = rd; v.a = a; v.b = b; v.imm = imm;
        v.wr = wr; v.wd = wd; v.fl = fl; v.we_n = we_n; v.rdy_n = rdy_n; v.ill = ill;
        return v;
    endfunction

    // Regfile model written by the DUT's write port.
    always @(posedge clk) begin
        if (we) rf[waddr] <= wdata;
    end

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=we@%0h/%0h required=no_write", waddr, wdata);
            end else begin
                sb_e = sbq.pop_front();
                chk("wb_addr", 32'(waddr), 32'(sb_e[10:8]));
                chk("wb_data", 32'(wdata), 32'(sb_e[7:0]));
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit hold, input string nm);
        int we_cnt, we_at, rdy_at, ill_cnt;
        @(negedge clk);
        chk({nm, "_ready_in"}, 32'(in_ready), 32'd1);
        in_op = v.op; in_rd = v.rd; in_a = v.a; in_b = v.b; in_imm = v.imm;
        in_valid = 1'b1;
        if (v.wr) sbq.push_back({v.rd, v.wd});
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        we_cnt = 0; we_at = 0; rdy_at = 0; ill_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (we) begin we_cnt++; we_at = n; end
            if (illegal) ill_cnt++;
            if (in_ready) begin rdy_at = n; break; end
        end
        in_valid = 1'b0;
        chk({nm, "_we_count"}, 32'(we_cnt), v.wr ? 32'd1 : 32'd0);
        chk({nm, "_we_cycle"}, 32'(we_at), v.wr ? 32'(v.we_n) : 32'd0);
        chk({nm, "_ready_cycle"}, 32'(rdy_at), 32'(v.rdy_n));
        chk({nm, "_illegal"}, 32'(ill_cnt), 32'(v.ill));
        chk({nm, "_flags"}, 32'(flags), 32'(v.fl));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        if (v.wr) chk({nm, "_rf"}, 32'(rf[v.rd]), 32'(v.wd));
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            chk({nm, "_hold_no_second"}, 32'(sbq.size()), 32'd0);
            chk({nm, "_hold_idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    vec_t vt[21];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_rd = 3'd0;
        in_a = 8'h00; in_b = 8'h00; in_imm = 8'h00;

        // flags layout {V,N,C,Z}
        vt[0]  = mk(OP_ADD,  3'd3, 8'h7F, 8'h01, 8'h00, 1'b1, 8'h80, 4'b1100, 1, 2, 0);
        vt[1]  = mk(OP_SUB,  3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 8'h00, 4'b0001, 1, 2, 0);
        vt[2]  = mk(OP_CMP,  3'd2, 8'h03, 8'h05, 8'h00, 1'b0, 8'h00, 4'b0110, 0, 1, 0);
        vt[3]  = mk(OP_MUL,  3'd6, 8'h0D, 8'h0B, 8'h00, 1'b1, 8'h8F, 4'b0100, 9, 10, 0);
        vt[4]  = mk(OP_INC,  3'd2, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0011, 1, 2, 0);
        vt[5]  = mk(OP_AND,  3'd0, 8'hF0, 8'h3C, 8'h00, 1'b1, 8'h30, 4'b0000, 1, 2, 0);
        vt[6]  = mk(OP_OR,   3'd4, 8'h0F, 8'h30, 8'h00, 1'b1, 8'h3F, 4'b0000, 1, 2, 0);
        vt[7]  = mk(OP_XOR,  3'd5, 8'hAA, 8'hFF, 8'h00, 1'b1, 8'h55, 4'b0000, 1, 2, 0);
        vt[8]  = mk(OP_SHL,  3'd1, 8'h81, 8'h00, 8'h00, 1'b1, 8'h02, 4'b0010, 1, 2, 0);
        vt[9]  = mk(OP_SHR,  3'd2, 8'h81, 8'h00, 8'h00, 1'b1, 8'h40, 4'b0010, 1, 2, 0);
        vt[10] = mk(OP_MOV,  3'd1, 8'h00, 8'h9C, 8'h00, 1'b1, 8'h9C, 4'b0100, 1, 2, 0);
        vt[11] = mk(OP_LDI,  3'd7, 8'h11, 8'h22, 8'h00, 1'b1, 8'h00, 4'b0001, 1, 2, 0);
        vt[12] = mk(OP_ADDI, 3'd3, 8'hFF, 8'h00, 8'h01, 1'b1, 8'h00, 4'b0011, 1, 2, 0);
        vt[13] = mk(OP_DEC,  3'd4, 8'h00, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0110, 1, 2, 0);
        vt[14] = mk(OP_DEC,  3'd4, 8'h80, 8'h00, 8'h00, 1'b1, 8'h7F, 4'b1000, 1, 2, 0);
        vt[15] = mk(OP_SUB,  3'd5, 8'h00, 8'h01, 8'h00, 1'b1, 8'hFF, 4'b0110, 1, 2, 0);
        vt[16] = mk(OP_NOP,  3'd5, 8'h12, 8'h34, 8'h00, 1'b0, 8'h00, 4'b0110, 0, 1, 0);
        vt[17] = mk(OP_RSVD, 3'd5, 8'h12, 8'h34, 8'h00, 1'b0, 8'h00, 4'b0110, 0, 1, 1);
        vt[18] = mk(OP_ADD,  3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 8'h00, 4'b0011, 1, 2, 0);
        vt[19] = mk(OP_MUL,  3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1, 8'h01, 4'b0000, 9, 10, 0);
        vt[20] = mk(OP_ADD,  3'd3, 8'h80, 8'h80, 8'h00, 1'b1, 8'h00, 4'b1011, 1, 2, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_we", 32'(we), 32'd0);
        chk("post_rst_flags", 32'(flags), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 21; i++) run_vec(vt[i], 1'b0, $sformatf("vec%0d", i));

        run_vec(mk(OP_ADD, 3'd3, 8'h01, 8'h02, 8'h00, 1'b1, 8'h03, 4'b0000, 1, 2, 0),
                1'b1, "hold_add");
        run_vec(mk(OP_SUB, 3'd5, 8'h00, 8'h01, 8'h00, 1'b1, 8'hFF, 4'b0110, 1, 2, 0),
                1'b0, "pre_rst");

        // Reset four cycles into a multiply: the write must never appear.
        @(negedge clk);
        in_op = OP_MUL; in_rd = 3'd6; in_a = 8'h0D; in_b = 8'h0B; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("mulrst_no_we", 32'(we), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("mulrst_flags", 32'(flags), 32'd0);
        chk("mulrst_ready", 32'(in_ready), 32'd1);
        chk("mulrst_busy", 32'(busy), 32'd0);
        chk("mulrst_we", 32'(we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            chk("mulrst_after_no_we", 32'(we), 32'd0);
        end
        run_vec(mk(OP_LDI, 3'd7, 8'h00, 8'h00, 8'h5A, 1'b1, 8'h5A, 4'b0000, 1, 2, 0),
                1'b0, "ldi_after_rst");

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
